// File: rtl/saturn_alu_pkg.sv
// rtl/saturn_alu_pkg.sv - op codes and state encoding for the Saturn field ALU
package saturn_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_NEG = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_TFR = 4'd6;
    localparam logic [3:0] OP_CLR = 4'd7;
    localparam logic [3:0] OP_SL  = 4'd8;
    localparam logic [3:0] OP_SR  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/saturn_digit_unit.sv
// rtl/saturn_digit_unit.sv - one-nibble hex/BCD add or subtract with carry/borrow
module saturn_digit_unit (
    input  logic       decimal,
    input  logic       sub,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    // Decimal correction is applied mod 16, so out-of-range BCD digits pass through untrapped.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        diff = {1'b0, a} - {1'b0, b} - {4'b0, cin};
        if (sub) begin
            cout = diff[4];
            s    = diff[3:0] + ((diff[4] && decimal) ? 4'd10 : 4'd0);
        end else begin
            cout = (sum >= (decimal ? 5'd10 : 5'd16));
            s    = sum[3:0] + ((cout && decimal) ? 4'd6 : 4'd0);
        end
    end

endmodule

// File: rtl/saturn_field_alu.sv
// rtl/saturn_field_alu.sv - multi-cycle field-masked nibble ALU; SATURN_FIELD_ALU_SHIFT_EN adds SL/SR
module saturn_field_alu
    import saturn_alu_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int LANES   = 1
) (
    input  logic                         clk_in,
    input  logic                         reset_in,
    input  logic                         start_in,
    input  logic [3:0]                   alu_op_in,
    input  logic                         decimal_in,
    input  logic [$clog2(NIBBLES)-1:0]   left_mask_in,
    input  logic [$clog2(NIBBLES)-1:0]   right_mask_in,
    input  logic [4*NIBBLES-1:0]         op1_in,
    input  logic [4*NIBBLES-1:0]         op2_in,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [4*NIBBLES-1:0]         result_o,
    output logic                         carry_o,
    output logic                         zero_o,
    output logic                         sb_o
);

    localparam int IW = $clog2(NIBBLES);

    state_t               state, state_next;
    logic [3:0]           op_q;
    logic                 dec_q;
    logic [4*NIBBLES-1:0] op1_q, op2_q, result_next;
    logic [IW-1:0]        cursor, span;
    logic [IW:0]          remaining, field_len, step;
    logic                 carry_int, zero_int, carry_final, zero_next;
    logic                 accept, last, is_sub, is_arith, seed;
    logic [LANES-1:0]     lane_act, lane_zero;
    logic [4*LANES-1:0]   lane_vals;
    logic [IW*LANES-1:0]  lane_pos;

    assign accept    = start_in && (state == ST_IDLE || state == ST_DONE);
    assign span      = left_mask_in - right_mask_in;
    assign field_len = {1'b0, span} + (IW+1)'(1);
    assign last      = (remaining <= (IW+1)'(LANES));
    assign step      = last ? remaining : (IW+1)'(LANES);
    assign is_sub    = (op_q == OP_SUB) || (op_q == OP_DEC);
    assign is_arith  = (op_q <= OP_NEG);
    assign seed      = (alu_op_in == OP_INC) || (alu_op_in == OP_DEC) || (alu_op_in == OP_NEG);

`ifdef SATURN_FIELD_ALU_SHIFT_EN
    logic [IW-1:0] left_q, right_q;
    logic          sb_q;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            left_q  <= '0;
            right_q <= '0;
            sb_q    <= 1'b0;
        end else if (accept) begin
            left_q  <= left_mask_in;
            right_q <= right_mask_in;
        end else if (state == ST_RUN && last) begin
            sb_q <= (op_q == OP_SR) && (op1_q[4*right_q +: 4] != 4'd0);
        end
    end
    assign sb_o = sb_q;
`else
    assign sb_o = 1'b0;
`endif

    // NEG runs as nines/fifteens complement plus a seeded carry; its borrow is the inverted carry.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [IW-1:0] p;
        logic [3:0]    na, nb, nc, x, y, ds, val;
        logic          act, cin, cout, cpass;

        assign p   = cursor + IW'(j);
        assign act = remaining > (IW+1)'(j);
        assign na  = op1_q[4*p +: 4];
        assign nb  = op2_q[4*p +: 4];
        assign nc  = (dec_q ? 4'd9 : 4'd15) - na;
        assign x   = (op_q == OP_NEG) ? nc : na;
        assign y   = (op_q == OP_ADD || op_q == OP_SUB) ? nb : 4'd0;

        if (j == 0) begin : g_seed
            assign cin = carry_int;
        end else begin : g_ripple
            assign cin = g_lane[j-1].cpass;
        end

        saturn_digit_unit u_digit (
            .decimal (dec_q),
            .sub     (is_sub),
            .a       (x),
            .b       (y),
            .cin     (cin),
            .s       (ds),
            .cout    (cout)
        );

        assign cpass = act ? cout : cin;

`ifdef SATURN_FIELD_ALU_SHIFT_EN
        logic [IW-1:0] pdn, pup;
        assign pdn = p - IW'(1);
        assign pup = p + IW'(1);
`endif

        always_comb begin
            val = na;
            case (op_q)
                OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: val = ds;
                OP_NOT: val = nc;
                OP_TFR: val = nb;
                OP_CLR: val = 4'd0;
`ifdef SATURN_FIELD_ALU_SHIFT_EN
                OP_SL:  val = (p == right_q) ? 4'd0 : op1_q[4*pdn +: 4];
                OP_SR:  val = (p == left_q)  ? 4'd0 : op1_q[4*pup +: 4];
`endif
                default: val = na;
            endcase
        end

        assign lane_vals[4*j +: 4]  = val;
        assign lane_pos[IW*j +: IW] = p;
        assign lane_act[j]          = act;
        assign lane_zero[j]         = !act || (val == 4'd0);
    end

    assign carry_final = g_lane[LANES-1].cpass;
    assign zero_next   = zero_int && (&lane_zero);

    always_comb begin
        result_next = result_o;
        for (int j = 0; j < LANES; j++) begin
            if (lane_act[j]) result_next[4*lane_pos[IW*j +: IW] +: 4] = lane_vals[4*j +: 4];
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state)
            ST_IDLE: if (start_in) state_next = ST_RUN;
            ST_RUN: begin
                busy_o = 1'b1;
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                done_o     = 1'b1;
                state_next = start_in ? ST_RUN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            dec_q     <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            cursor    <= '0;
            remaining <= '0;
            carry_int <= 1'b0;
            zero_int  <= 1'b0;
            result_o  <= '0;
            carry_o   <= 1'b0;
            zero_o    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q      <= alu_op_in;
                dec_q     <= decimal_in;
                op1_q     <= op1_in;
                op2_q     <= op2_in;
                result_o  <= op1_in;
                cursor    <= right_mask_in;
                remaining <= field_len;
                carry_int <= seed;
                zero_int  <= 1'b1;
            end else if (state == ST_RUN) begin
                result_o  <= result_next;
                cursor    <= cursor + step[IW-1:0];
                remaining <= remaining - step;
                carry_int <= carry_final;
                zero_int  <= zero_next;
                if (last) begin
                    carry_o <= is_arith && ((op_q == OP_NEG) ? !carry_final : carry_final);
                    zero_o  <= zero_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_saturn_field_alu.sv
// tb/tb_saturn_field_alu.sv - randomized and directed bench for saturn_field_alu (LANES 1 and 4)
module tb_saturn_field_alu;

    logic        clk = 1'b0;
    logic        reset, start, decimal;
    logic [3:0]  alu_op, left_mask, right_mask;
    logic [63:0] op1, op2;
    logic        busy1, done1, carry1, zero1, sb1;
    logic        busy4, done4, carry4, zero4, sb4;
    logic [63:0] res1, res4;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    saturn_field_alu #(.NIBBLES(16), .LANES(1)) dut1 (
        .clk_in(clk), .reset_in(reset), .start_in(start), .alu_op_in(alu_op),
        .decimal_in(decimal), .left_mask_in(left_mask), .right_mask_in(right_mask),
        .op1_in(op1), .op2_in(op2), .busy_o(busy1), .done_o(done1), .result_o(res1),
        .carry_o(carry1), .zero_o(zero1), .sb_o(sb1)
    );

    saturn_field_alu #(.NIBBLES(16), .LANES(4)) dut4 (
        .clk_in(clk), .reset_in(reset), .start_in(start), .alu_op_in(alu_op),
        .decimal_in(decimal), .left_mask_in(left_mask), .right_mask_in(right_mask),
        .op1_in(op1), .op2_in(op2), .busy_o(busy4), .done_o(done4), .result_o(res4),
        .carry_o(carry4), .zero_o(zero4), .sb_o(sb4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Digit-serial reference over the field, with borrow semantics for NEG taken directly as 0 - a.
    function automatic void model(input logic [3:0] op, input logic dec, input logic [3:0] lft,
                                  input logic [3:0] rgt, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output logic c, output logic z,
                                  output logic sb);
        int r, len, p, an, bn, v, cy;
        r   = dec ? 10 : 16;
        len = ((int'(lft) - int'(rgt)) & 15) + 1;
        cy  = (op == 4'd2 || op == 4'd3) ? 1 : 0;
        res = a;
        z   = 1'b1;
        sb  = 1'b0;
        for (int i = 0; i < len; i++) begin
            p  = (int'(rgt) + i) & 15;
            an = int'(a[p*4 +: 4]);
            bn = int'(b[p*4 +: 4]);
            case (op)
                4'd0, 4'd2: begin
                    v  = an + ((op == 4'd0) ? bn : 0) + cy;
                    cy = (v >= r) ? 1 : 0;
                    if (cy == 1) v -= r;
                end
                4'd1, 4'd3, 4'd4: begin
                    v  = ((op == 4'd4) ? 0 : an) - ((op == 4'd1) ? bn : (op == 4'd4) ? an : 0) - cy;
                    cy = (v < 0) ? 1 : 0;
                    if (cy == 1) v += r;
                end
                4'd5: v = r - 1 - an;
                4'd6: v = bn;
                4'd7: v = 0;
`ifdef SATURN_FIELD_ALU_SHIFT_EN
                4'd8: v = (p == int'(rgt)) ? 0 : int'(a[((p + 15) & 15)*4 +: 4]);
                4'd9: v = (p == int'(lft)) ? 0 : int'(a[((p + 1) & 15)*4 +: 4]);
`endif
                default: v = an;
            endcase
            res[p*4 +: 4] = 4'(v & 15);
            if ((v & 15) != 0) z = 1'b0;
        end
        c = (op <= 4'd4) && (cy == 1);
`ifdef SATURN_FIELD_ALU_SHIFT_EN
        sb = (op == 4'd9) && (a[int'(rgt)*4 +: 4] != 4'd0);
`endif
    endfunction

    function automatic logic [63:0] bcd(input logic [63:0] v);
        logic [63:0] o;
        for (int i = 0; i < 16; i++) o[i*4 +: 4] = 4'(v[i*4 +: 4] % 10);
        return o;
    endfunction

    // Entered and left at a negedge; returns at the negedge where both DUTs have reported done.
    task automatic run_op(input string tag, input logic [3:0] op, input logic dec, input logic [3:0] lft,
                          input logic [3:0] rgt, input logic [63:0] a, input logic [63:0] b,
                          input bit mid_start);
        logic [63:0] er, r1, r4;
        logic        ec, ez, esb, c1, c4, z1, z4, s1, s4;
        int          len, lat1, lat4;
        model(op, dec, lft, rgt, a, b, er, ec, ez, esb);
        len = ((int'(lft) - int'(rgt)) & 15) + 1;
        alu_op = op; decimal = dec; left_mask = lft; right_mask = rgt; op1 = a; op2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat1 = 0; lat4 = 0;
        r1 = 'x; r4 = 'x; c1 = 'x; c4 = 'x; z1 = 'x; z4 = 'x; s1 = 'x; s4 = 'x;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 1) begin
                chk({tag, " busy"}, {62'b0, busy1, busy4}, 64'd3);
                if (mid_start) begin start = 1'b1; op1 = ~a; end
            end
            if (n == 2 && mid_start) begin start = 1'b0; op1 = a; end
            if (lat4 != 0 && n == lat4 + 1) chk({tag, " pulse4"}, 64'(done4), 64'd0);
            if (lat1 == 0 && done1) begin lat1 = n; r1 = res1; c1 = carry1; z1 = zero1; s1 = sb1; end
            if (lat4 == 0 && done4) begin lat4 = n; r4 = res4; c4 = carry4; z4 = zero4; s4 = sb4; end
            if (lat1 != 0 && lat4 != 0) break;
        end
        chk({tag, " lat1"}, 64'(lat1), 64'(len + 1));
        chk({tag, " lat4"}, 64'(lat4), 64'((len + 3) / 4 + 1));
        chk({tag, " res1"}, r1, er);
        chk({tag, " res4"}, r4, er);
        chk({tag, " carry"}, {62'b0, c1, c4}, {62'b0, ec, ec});
        chk({tag, " zero"}, {62'b0, z1, z4}, {62'b0, ez, ez});
        chk({tag, " sb"}, {62'b0, s1, s4}, {62'b0, esb, esb});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, b;
        logic [3:0]  op, lft, rgt;
        logic        dec;
        bit          saw;
        int          gap;

        reset = 1'b1; start = 1'b0; alu_op = '0; decimal = 1'b0;
        left_mask = '0; right_mask = '0; op1 = '0; op2 = '0;
        repeat (3) @(negedge clk);
        chk("reset ctl", {58'b0, busy1, done1, busy4, done4, carry1, carry4}, 64'd0);
        chk("reset flags", {60'b0, zero1, zero4, sb1, sb4}, 64'd0);
        chk("reset res1", res1, 64'd0);
        chk("reset res4", res4, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("hex_add_full", 4'd0, 1'b0, 4'd15, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_op("dec_add", 4'd0, 1'b1, 4'd2, 4'd0, 64'h1234_5678_9ABC_D999, 64'd1, 1'b0);
        run_op("hex_sub", 4'd1, 1'b0, 4'd0, 4'd0, 64'd3, 64'd5, 1'b0);
        run_op("wrap_clr", 4'd7, 1'b0, 4'd1, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        run_op("carry_stop", 4'd0, 1'b0, 4'd15, 4'd0, 64'h0FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_op("neg_zero", 4'd4, 1'b0, 4'd3, 4'd0, 64'hABCD_0000_0000_0000, 64'd0, 1'b0);
        run_op("dec_neg", 4'd4, 1'b1, 4'd3, 4'd0, 64'h0000_0000_0000_0125, 64'd0, 1'b0);

        @(negedge clk);
        alu_op = 4'd0; decimal = 1'b0; left_mask = 4'd15; right_mask = 4'd0;
        op1 = 64'h0123_4567_89AB_CDEF; op2 = 64'h1111_1111_1111_1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {62'b0, busy1, busy4}, 64'd0);
        chk("abort res1", res1, 64'd0);
        chk("abort res4", res4, 64'd0);
        saw = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (done1 || done4) saw = 1'b1;
            @(negedge clk);
        end
        chk("abort nodone", 64'(saw), 64'd0);

        run_op("shift_sr", 4'd9, 1'b0, 4'd3, 4'd0, 64'h0000_0000_0000_1234, 64'd0, 1'b0);
        run_op("shift_sl", 4'd8, 1'b0, 4'd1, 4'd14, 64'h1234_5678_9ABC_DEF1, 64'd0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            op  = 4'($urandom_range(0, 15));
            dec = 1'($urandom_range(0, 1));
            lft = 4'($urandom_range(0, 15));
            rgt = 4'($urandom_range(0, 15));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            if (dec) begin a = bcd(a); b = bcd(b); end
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                @(negedge clk);
                chk("pulse1", 64'(done1), 64'd0);
            end
            run_op($sformatf("rnd%0d_op%0d", t, op), op, dec, lft, rgt, a, b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/saturn_field_alu.md
Name: saturn_field_alu

Overview:
Multi-cycle, field-masked nibble ALU for the parallel Saturn core. It is the parametrised successor of the single-shot ALU path inside saturn_alru.
- Processes the field between right_mask_in and left_mask_in, LANES nibbles per clock.
- Supports hex and decimal (BCD) arithmetic.
- Nibbles outside the field keep their op1 value.
- Uses a start/busy/done handshake so the sequencer can trade area for cycles.

Parameters:
NIBBLES, 16, register width in nibbles (power of 2, 4..32)
LANES, 1, nibbles processed per cycle (1, 2 or 4; must divide NIBBLES)

Ports:
clk_in  input  1  clock, rising edge
reset_in  input  1  synchronous, active-high reset
start_in  input  1  begin an operation (accepted in IDLE or DONE)
alu_op_in  input  4  operation code (saturn_alu_pkg)
decimal_in  input  1  1 = BCD digit arithmetic, 0 = hex
left_mask_in  input  $clog2(NIBBLES)  most significant field nibble index
right_mask_in  input  $clog2(NIBBLES)  least significant field nibble index
op1_in  input  4*NIBBLES  first operand, also the value kept outside the field
op2_in  input  4*NIBBLES  second operand
busy_o  output  1  operation in progress
done_o  output  1  one-cycle pulse; result_o, carry_o, zero_o valid
result_o  output  4*NIBBLES  result register
carry_o  output  1  final carry (ADD/INC) or borrow (SUB/DEC/NEG)
zero_o  output  1  all field nibbles of result are zero
sb_o  output  1  sticky bit (shift ops only; 0 otherwise)

Behaviour:
- Reset: state IDLE; busy_o, done_o, carry_o, zero_o, sb_o = 0; result_o = 0. A reset mid-operation aborts it with no done pulse.
- States and transitions:
  - IDLE/DONE --start_in--> RUN. At the start edge: latch op1, op2, op, decimal and masks; result_o <= op1_in; cursor <= right_mask; carry_int <= 0 (1 for INC/DEC/NEG seed).
  - RUN, each cycle: process k = min(LANES, nibbles remaining) nibbles from the cursor upward. Carry ripples across the lanes inside the cycle. cursor += k, modulo NIBBLES.
  - RUN --last field nibble done--> DONE. DONE lasts one cycle with done_o = 1, then returns to IDLE unless start_in is high.
- Field length L = ((left - right) mod NIBBLES) + 1. left < right means the field wraps from NIBBLES-1 to 0. left == right means L = 1.
- Latency: start edge to done_o = ceil(L/LANES) + 1 cycles. busy_o is high in RUN only.
- start_in while in RUN is ignored. start_in in DONE is accepted, giving back-to-back operations.
- Per digit, radix R = 10 if decimal else 16:
  - ADD: s = a+b+c; if s >= R then s -= R, c = 1.
  - SUB: d = a-b-c; if d < 0 then d += R, c = 1.
  - INC: a + 1.
  - DEC: a - 1.
  - NEG: 0 - a.
  - NOT: (R-1) - a.
  - TFR: result = b.
  - CLR: result = 0.
  - Decimal digits > 9 are not trapped; the result is taken mod 16.
- carry_o and zero_o update on entry to DONE and hold until the next start.

Optional Feature:
SATURN_FIELD_ALU_SHIFT_EN:
- Defined: op 8 = SL, op 9 = SR, one nibble within the field.
  - SL: each field nibble takes the op1 nibble below it; the right field nibble becomes 0.
  - SR: each field nibble takes the op1 nibble above it; the left field nibble becomes 0. sb_o is set if the shifted-out right nibble is non-zero.
- Undefined: codes 8-15 leave result = op1 with carry_o = 0 and sb_o tied to 0.
- In both builds, codes 10-15 behave as the undefined case.

Decomposition:
- saturn_alu_pkg: op code localparams (ADD=0, SUB=1, INC=2, DEC=3, NEG=4, NOT=5, TFR=6, CLR=7, SL=8, SR=9) and the state enum.
- Sub-module saturn_digit_unit: combinational single-nibble add/sub with decimal correction. It is instantiated LANES times and chained on carry.

Test Plan:
- Hex ADD, left=15 right=0, op1=64'hFFFF_FFFF_FFFF_FFFF, op2=1 -> result 0, carry_o=1, zero_o=1, done_o 17 cycles after start.
- Decimal ADD, left=2 right=0, op1=64'h1234_5678_9ABC_D999, op2=1 -> result 64'h1234_5678_9ABC_D000, carry_o=1, done at cycle 4.
- Hex SUB, left=right=0, op1=3, op2=5 -> nibble 0 = 4'hE, carry_o=1; zero_o=0.
- Wrap CLR, left=1 right=14, op1 all F -> result 64'h00FF_FFFF_FFFF_FF00, done at cycle 5; start_in pulsed mid-RUN has no effect.
- LANES=4, hex ADD full field, op1=64'h0FFF_FFFF_FFFF_FFFF, op2=1 -> 64'h1000_0000_0000_0000, carry_o=0, done at cycle 5.
- reset_in asserted in the 3rd RUN cycle -> next cycle busy_o=0, result_o=0, no done_o. Then, with SATURN_FIELD_ALU_SHIFT_EN, SR over left=3 right=0 on op1=16'h1234 -> 16'h0123, sb_o=1.
